// File: rtl/da_wave_pkg.sv
// Shared constants and helpers for the DDS wave sender.
package da_wave_pkg;

  localparam int WAVE_NUM = 4;

  function automatic int midscale(input int data_w);
    return 1 << (data_w - 1);
  endfunction

  function automatic int unity_amp(input int amp_w);
    return 1 << (amp_w - 1);
  endfunction

endpackage

// File: rtl/da_phase_acc.sv
// Phase accumulator with pending/active tuning word and wave select.
// Changes are applied only at a period boundary, or at once while the phase is stalled.
module da_phase_acc
  import da_wave_pkg::*;
#(
  parameter int WAVE_NUM = da_wave_pkg::WAVE_NUM,
  parameter int SEL_W    = 2,
  parameter int ADDR_W   = 8,
  parameter int ACC_W    = 16,
  parameter int FTW_RST  = 1 << (ACC_W - ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [SEL_W-1:0]  wave_sel,
  input  logic [ACC_W-1:0]  ftw,
  input  logic              ftw_load,
  output logic [ADDR_W-1:0] phase_next,
  output logic [SEL_W-1:0]  sel_next,
  output logic              wrap
);

  logic [ACC_W-1:0] acc, acc_next;
  logic [ACC_W-1:0] ftw_act, ftw_pend;
  logic [SEL_W-1:0] sel_act, sel_pend;
  logic [ACC_W:0]   sum;
  logic             carry, apply;

  // A zero tuning word never carries, so pending values are taken without a boundary.
  always_comb begin
    sum        = {1'b0, acc} + {1'b0, ftw_act};
    carry      = en && sum[ACC_W];
    apply      = en && (sum[ACC_W] || (ftw_act == '0));
    acc_next   = en ? sum[ACC_W-1:0] : acc;
    sel_next   = apply ? sel_pend : sel_act;
    phase_next = acc_next[ACC_W-1 -: ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      ftw_act  <= ACC_W'(FTW_RST);
      ftw_pend <= ACC_W'(FTW_RST);
      sel_act  <= '0;
      sel_pend <= '0;
      wrap     <= 1'b0;
    end else begin
      acc  <= acc_next;
      wrap <= carry;
      if (apply) begin
        ftw_act <= ftw_pend;
        sel_act <= sel_pend;
      end
      if (ftw_load)
        ftw_pend <= ftw;
      if (int'(wave_sel) < WAVE_NUM)
        sel_pend <= wave_sel;
    end
  end

endmodule

// File: rtl/da_wave_dds.sv
// DDS wave sender: ROM address formation from the phase accumulator, amplitude
// scaling with saturation, and the DAC clock.
module da_wave_dds
  import da_wave_pkg::*;
#(
  parameter int WAVE_NUM = da_wave_pkg::WAVE_NUM,
  parameter int SEL_W    = 2,
  parameter int ADDR_W   = 8,
  parameter int ACC_W    = 16,
  parameter int DATA_W   = 8,
  parameter int AMP_W    = 9,
  parameter int FTW_RST  = 1 << (ACC_W - ADDR_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [SEL_W-1:0]        wave_sel,
  input  logic [ACC_W-1:0]        ftw,
  input  logic                    ftw_load,
  input  logic [AMP_W-1:0]        amp,
  output logic [SEL_W+ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]       rd_data,
  output logic                    wrap,
  output logic                    da_clk,
  output logic [DATA_W-1:0]       da_data
);

  localparam int MID = midscale(DATA_W);
  localparam int PW  = DATA_W + AMP_W + 2;
  localparam logic signed [PW-1:0] MID_P = PW'(MID);
  localparam logic signed [PW-1:0] MAX_P = PW'((1 << DATA_W) - 1);

  logic [ADDR_W-1:0] phase_next;
  logic [SEL_W-1:0]  sel_next;

  da_phase_acc #(
    .WAVE_NUM (WAVE_NUM),
    .SEL_W    (SEL_W),
    .ADDR_W   (ADDR_W),
    .ACC_W    (ACC_W),
    .FTW_RST  (FTW_RST)
  ) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wave_sel   (wave_sel),
    .ftw        (ftw),
    .ftw_load   (ftw_load),
    .phase_next (phase_next),
    .sel_next   (sel_next),
    .wrap       (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_addr <= '0;
    else if (en)
      rd_addr <= {sel_next, phase_next};
  end

  logic signed [DATA_W:0] centred;
  logic signed [PW-1:0]   c_ext, a_ext, prod, scaled;

  // Offset-binary -> two's complement, scale, floor-shift, back to offset-binary.
  always_comb begin
    centred = $signed({1'b0, rd_data}) - $signed((DATA_W + 1)'(MID));
    c_ext   = {{(AMP_W + 1){centred[DATA_W]}}, centred};
    a_ext   = {{(DATA_W + 2){1'b0}}, amp};
    prod    = c_ext * a_ext;
    scaled  = (prod >>> (AMP_W - 1)) + MID_P;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      da_data <= DATA_W'(MID);
    else if (scaled < 0)
      da_data <= '0;
    else if (scaled > MAX_P)
      da_data <= '1;
    else
      da_data <= scaled[DATA_W-1:0];
  end

  assign da_clk = ~clk;

endmodule
